// File: rtl/mem_bus_arbiter.sv
// Arbitrates the single-port memory bus between the CPU datapath and a debug/loader port,
// and decodes the memory-mapped switch/LED word at IO_ADDR.
module mem_bus_arbiter #(
    parameter int          MEM_LATENCY = 2,
    parameter logic [15:0] IO_ADDR     = 16'h2000
) (
    input  logic        clock,
    input  logic        reset_L,
    input  logic        cpu_re_L,
    input  logic        cpu_we_L,
    input  logic [15:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    output logic [15:0] cpu_rdata,
    output logic        cpu_stall,
    input  logic        dbg_req,
    input  logic        dbg_we,
    input  logic [15:0] dbg_addr,
    input  logic [15:0] dbg_wdata,
    output logic [15:0] dbg_rdata,
    output logic        dbg_ack,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    output logic        mem_re_L,
    output logic        mem_we_L,
    input  logic [15:0] SW,
    output logic [15:0] LEDR
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_DBG = 1'b1;

    localparam int                CNT_W    = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(MEM_LATENCY - 1);

    logic [1:0]       state_r;
    logic             owner_r;
    logic             last_owner_r;
    logic             we_r;
    logic             io_r;
    logic [CNT_W-1:0] cnt_r;

    logic        cpu_pend_s;
    logic        dbg_pend_s;
    logic        grant_dbg_s;
    logic        sel_we_s;
    logic        sel_io_s;
    logic        last_cyc_s;
    logic [15:0] sel_addr_s;
    logic [15:0] sel_wdata_s;
    logic [15:0] cap_data_s;

    // Request decode, alternating tie-break and selection of the granted requester's fields.
    always_comb begin
        cpu_pend_s  = 1'b0;
        dbg_pend_s  = 1'b0;
        grant_dbg_s = 1'b0;
        sel_we_s    = 1'b0;
        sel_addr_s  = 16'h0000;
        sel_wdata_s = 16'h0000;
        cpu_pend_s  = (~cpu_re_L) | (~cpu_we_L);
        dbg_pend_s  = dbg_req;
        if (cpu_pend_s && dbg_pend_s) begin
            grant_dbg_s = (last_owner_r == OWN_CPU);
        end else if (dbg_pend_s) begin
            grant_dbg_s = 1'b1;
        end else begin
            grant_dbg_s = 1'b0;
        end
        // A CPU access with both strobes low is a write.
        if (grant_dbg_s) begin
            sel_we_s    = dbg_we;
            sel_addr_s  = dbg_addr;
            sel_wdata_s = dbg_wdata;
        end else begin
            sel_we_s    = ~cpu_we_L;
            sel_addr_s  = cpu_addr;
            sel_wdata_s = cpu_wdata;
        end
        sel_io_s   = (sel_addr_s == IO_ADDR);
        last_cyc_s = io_r | (cnt_r == CNT_LAST);
        cap_data_s = io_r ? SW : mem_rdata;
    end

    assign cpu_stall = cpu_pend_s & ~((state_r == ST_DONE) & (owner_r == OWN_CPU));

    // Access sequencer: grant in IDLE, strobe/decode in BUSY, one-cycle completion in DONE.
    always_ff @(posedge clock) begin
        if (!reset_L) begin
            state_r      <= ST_IDLE;
            owner_r      <= OWN_CPU;
            last_owner_r <= OWN_DBG;
            we_r         <= 1'b0;
            io_r         <= 1'b0;
            cnt_r        <= '0;
            cpu_rdata    <= 16'h0000;
            dbg_rdata    <= 16'h0000;
            dbg_ack      <= 1'b0;
            mem_addr     <= 16'h0000;
            mem_wdata    <= 16'h0000;
            mem_re_L     <= 1'b1;
            mem_we_L     <= 1'b1;
            LEDR         <= 16'h0000;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    dbg_ack <= 1'b0;
                    if (cpu_pend_s || dbg_pend_s) begin
                        owner_r      <= grant_dbg_s;
                        last_owner_r <= grant_dbg_s;
                        we_r         <= sel_we_s;
                        io_r         <= sel_io_s;
                        cnt_r        <= '0;
                        mem_addr     <= sel_addr_s;
                        mem_wdata    <= sel_wdata_s;
                        mem_re_L     <= sel_io_s | sel_we_s;
                        mem_we_L     <= sel_io_s | ~sel_we_s;
                        state_r      <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (last_cyc_s) begin
                        mem_re_L <= 1'b1;
                        mem_we_L <= 1'b1;
                        dbg_ack  <= (owner_r == OWN_DBG);
                        state_r  <= ST_DONE;
                        if (!we_r) begin
                            if (owner_r == OWN_DBG) begin
                                dbg_rdata <= cap_data_s;
                            end else begin
                                cpu_rdata <= cap_data_s;
                            end
                        end else if (io_r) begin
                            LEDR <= mem_wdata;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    dbg_ack <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    dbg_ack  <= 1'b0;
                    mem_re_L <= 1'b1;
                    mem_we_L <= 1'b1;
                    state_r  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios plus randomized alternating
// traffic checked against a behavioural memory/LED reference model.
module tb_mem_bus_arbiter;

    localparam int          L  = 2;
    localparam logic [15:0] IO = 16'h2000;

    logic        clock = 1'b0;
    logic        reset_L;
    logic        cpu_re_L, cpu_we_L;
    logic [15:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_stall;
    logic        dbg_req, dbg_we;
    logic [15:0] dbg_addr, dbg_wdata, dbg_rdata;
    logic        dbg_ack;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_re_L, mem_we_L;
    logic [15:0] sw, ledr;

    int errors = 0;
    int checks = 0;
    int re_cyc = 0, we_cyc = 0, io_strobes = 0, far_strobes = 0, ack_cnt = 0;

    logic [15:0] env_mem [0:1023];
    bit          env_ready = 1'b0;
    logic [15:0] ref_mem [logic [15:0]];
    logic [15:0] ref_led = 16'h0000;
    byte         order_q[$];

    always #5 clock = ~clock;

    mem_bus_arbiter #(.MEM_LATENCY(L), .IO_ADDR(IO)) dut (
        .clock(clock), .reset_L(reset_L),
        .cpu_re_L(cpu_re_L), .cpu_we_L(cpu_we_L), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_rdata(dbg_rdata), .dbg_ack(dbg_ack),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_re_L(mem_re_L), .mem_we_L(mem_we_L), .SW(sw), .LEDR(ledr)
    );

    // Memory environment and bus monitors, sampled mid-cycle.
    always @(negedge clock) begin
        if (!env_ready) begin
            for (int i = 0; i < 1024; i++) env_mem[i] <= 16'(i) ^ 16'hBEAF;
            env_ready <= 1'b1;
        end else begin
            if (!mem_re_L) begin
                re_cyc    <= re_cyc + 1;
                mem_rdata <= env_mem[mem_addr[9:0]];
            end else begin
                mem_rdata <= 16'($urandom);
            end
            if (!mem_we_L) begin
                we_cyc <= we_cyc + 1;
                env_mem[mem_addr[9:0]] <= mem_wdata;
            end
            if ((!mem_re_L || !mem_we_L) && mem_addr == IO) io_strobes <= io_strobes + 1;
            if ((!mem_re_L || !mem_we_L) && mem_addr >= 16'h0400) far_strobes <= far_strobes + 1;
            if (dbg_ack) ack_cnt <= ack_cnt + 1;
        end
    end

    function automatic logic [15:0] ref_read(input logic [15:0] a);
        if (a == IO) return sw;
        else if (ref_mem.exists(a)) return ref_mem[a];
        else return a ^ 16'hBEAF;
    endfunction

    task automatic ref_write(input logic [15:0] a, input logic [15:0] d);
        if (a == IO) ref_led = d;
        else ref_mem[a] = d;
    endtask

    function automatic int exp_edges(input logic [15:0] a);
        return (a == IO) ? 2 : L + 1;
    endfunction

    task automatic cpu_do(input logic we, input logic [15:0] a, input logic [15:0] d,
                          output logic [15:0] rd, output int edges, output logic stall0);
        cpu_addr = a; cpu_wdata = d; cpu_re_L = we; cpu_we_L = ~we;
        #1 stall0 = cpu_stall;
        edges = 0;
        while (edges < 40) begin
            @(posedge clock); #1; edges++;
            if (!cpu_stall) break;
        end
        rd = cpu_rdata;
        cpu_re_L = 1'b1; cpu_we_L = 1'b1;
        @(posedge clock); #1;
    endtask

    task automatic dbg_do(input logic we, input logic [15:0] a, input logic [15:0] d,
                          output logic [15:0] rd, output int edges);
        logic got;
        dbg_addr = a; dbg_wdata = d; dbg_we = we; dbg_req = 1'b1;
        edges = 0; got = 1'b0;
        while (edges < 40 && !got) begin
            @(posedge clock); #1; edges++;
            got = dbg_ack;
        end
        rd = dbg_rdata;
        @(posedge clock); #1;
        dbg_req = 1'b0;
    endtask

    task automatic apply_reset();
        reset_L = 1'b0; cpu_re_L = 1'b1; cpu_we_L = 1'b1; dbg_req = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset_L = 1'b1;
        ref_led = 16'h0000;
        @(posedge clock); #1;
    endtask

    task automatic test_reset();
        reset_L = 1'b0; cpu_re_L = 1'b1; cpu_we_L = 1'b1; dbg_req = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        checks++; if (mem_re_L !== 1'b1 || mem_we_L !== 1'b1) begin errors++; $display("FAIL reset_strobes got re=%b we=%b want 1 1", mem_re_L, mem_we_L); end
        checks++; if (cpu_rdata !== 16'h0 || dbg_rdata !== 16'h0) begin errors++; $display("FAIL reset_rdata got cpu=%h dbg=%h want 0 0", cpu_rdata, dbg_rdata); end
        checks++; if (ledr !== 16'h0 || dbg_ack !== 1'b0) begin errors++; $display("FAIL reset_led_ack got led=%h ack=%b want 0 0", ledr, dbg_ack); end
        checks++; if (mem_addr !== 16'h0 || mem_wdata !== 16'h0) begin errors++; $display("FAIL reset_bus got addr=%h wdata=%h want 0 0", mem_addr, mem_wdata); end
        checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", cpu_stall); end
        reset_L = 1'b1;
        @(posedge clock); #1;
    endtask

    task automatic test_reset_mid_access();
        logic [15:0] rd;
        int          e, a0;
        cpu_addr = IO; cpu_wdata = 16'hFFFF; cpu_we_L = 1'b0; cpu_re_L = 1'b1;
        @(posedge clock); #1;
        reset_L = 1'b0; cpu_we_L = 1'b1;
        a0 = ack_cnt;
        @(posedge clock); #1;
        checks++; if (ledr !== 16'h0) begin errors++; $display("FAIL midreset_led got %h want 0000", ledr); end
        checks++; if (mem_re_L !== 1'b1 || mem_we_L !== 1'b1) begin errors++; $display("FAIL midreset_strobes got re=%b we=%b want 1 1", mem_re_L, mem_we_L); end
        reset_L = 1'b1;
        ref_led = 16'h0000;
        repeat (3) @(posedge clock);
        #1;
        checks++; if (ledr !== 16'h0 || ack_cnt != a0) begin errors++; $display("FAIL midreset_after got led=%h acks=%0d want 0000 0", ledr, ack_cnt - a0); end
        dbg_do(1'b0, 16'h0010, 16'h0, rd, e);
        checks++; if (e != L + 1 || rd !== ref_read(16'h0010)) begin errors++; $display("FAIL midreset_idle got edges=%0d rd=%h want %0d %h", e, rd, L + 1, ref_read(16'h0010)); end
    endtask

    task automatic test_cpu_mem_read();
        logic [15:0] rd;
        int          e, r0, w0;
        logic        s0;
        r0 = re_cyc; w0 = we_cyc;
        cpu_do(1'b0, 16'h0040, 16'h0, rd, e, s0);
        checks++; if (s0 !== 1'b1 || e != L + 1) begin errors++; $display("FAIL cpu_read_stall got first=%b edges=%0d want 1 %0d", s0, e, L + 1); end
        checks++; if (rd !== 16'hBEEF) begin errors++; $display("FAIL cpu_read_data got %h want BEEF", rd); end
        checks++; if (re_cyc - r0 != L || we_cyc != w0) begin errors++; $display("FAIL cpu_read_strobe got re=%0d we=%0d want %0d 0", re_cyc - r0, we_cyc - w0, L); end
    endtask

    task automatic test_cpu_io();
        logic [15:0] rd;
        int          e, r0, w0, i0;
        logic        s0;
        r0 = re_cyc; w0 = we_cyc; i0 = io_strobes;
        cpu_do(1'b1, IO, 16'h00A5, rd, e, s0);
        ref_write(IO, 16'h00A5);
        checks++; if (e != 2) begin errors++; $display("FAIL io_write_latency got %0d want 2", e); end
        checks++; if (ledr !== ref_led) begin errors++; $display("FAIL io_write_led got %h want %h", ledr, ref_led); end
        checks++; if (re_cyc != r0 || we_cyc != w0 || io_strobes != i0) begin errors++; $display("FAIL io_write_nostrobe got re=%0d we=%0d io=%0d want 0 0 0", re_cyc - r0, we_cyc - w0, io_strobes - i0); end
        checks++; if (rd !== 16'hBEEF) begin errors++; $display("FAIL io_rdata_hold got %h want BEEF", rd); end
        sw = 16'h1234;
        cpu_do(1'b0, IO, 16'h0, rd, e, s0);
        checks++; if (rd !== 16'h1234 || e != 2) begin errors++; $display("FAIL io_read got rd=%h edges=%0d want 1234 2", rd, e); end
    endtask

    task automatic test_tie_alternation();
        logic [15:0] crd, drd;
        int          ce, de;
        logic        s0;
        apply_reset();
        for (int round = 0; round < 2; round++) begin
            fork
                cpu_do(1'b0, 16'h0044, 16'h0, crd, ce, s0);
                dbg_do(1'b0, 16'h0048, 16'h0, drd, de);
            join
            checks++; if (ce != L + 1) begin errors++; $display("FAIL tie_cpu_first round=%0d got edges=%0d want %0d", round, ce, L + 1); end
            checks++; if (de != 2 * L + 3) begin errors++; $display("FAIL tie_dbg_next round=%0d got edges=%0d want %0d", round, de, 2 * L + 3); end
            checks++; if (crd !== ref_read(16'h0044) || drd !== ref_read(16'h0048)) begin errors++; $display("FAIL tie_data got cpu=%h dbg=%h want %h %h", crd, drd, ref_read(16'h0044), ref_read(16'h0048)); end
        end
    endtask

    task automatic test_dbg_write_read();
        logic [15:0] rd;
        int          e, a0, r0, w0;
        a0 = ack_cnt; w0 = we_cyc;
        dbg_do(1'b1, 16'h0100, 16'h5A5A, rd, e);
        ref_write(16'h0100, 16'h5A5A);
        checks++; if (e != L + 1 || ack_cnt - a0 != 1) begin errors++; $display("FAIL dbg_write_ack got edges=%0d acks=%0d want %0d 1", e, ack_cnt - a0, L + 1); end
        checks++; if (we_cyc - w0 != L) begin errors++; $display("FAIL dbg_write_strobe got %0d want %0d", we_cyc - w0, L); end
        a0 = ack_cnt; r0 = re_cyc;
        dbg_do(1'b0, 16'h0100, 16'h0, rd, e);
        checks++; if (rd !== ref_read(16'h0100) || ack_cnt - a0 != 1) begin errors++; $display("FAIL dbg_read got rd=%h acks=%0d want %h 1", rd, ack_cnt - a0, ref_read(16'h0100)); end
        checks++; if (re_cyc - r0 != L) begin errors++; $display("FAIL dbg_read_strobe got %0d want %0d", re_cyc - r0, L); end
    endtask

    function automatic logic [15:0] pick_addr();
        if ($urandom_range(0, 7) == 0) return IO;
        else return 16'h0200 + 16'($urandom_range(0, 7));
    endfunction

    task automatic test_back_to_back();
        int a0;
        sw = 16'($urandom);
        a0 = ack_cnt;
        order_q.delete();
        fork
            begin
                logic [15:0] a, d, rd, ex;
                logic        we, s0;
                int          e;
                for (int i = 0; i < 10; i++) begin
                    we = 1'($urandom_range(0, 1)); a = pick_addr(); d = 16'($urandom);
                    cpu_do(we, a, d, rd, e, s0);
                    order_q.push_back(8'd67);
                    checks++; if (e < exp_edges(a) || e > 2 * L + 3) begin errors++; $display("FAIL b2b_cpu_wait i=%0d got edges=%0d want %0d..%0d", i, e, exp_edges(a), 2 * L + 3); end
                    if (!we) begin
                        ex = ref_read(a);
                        checks++; if (rd !== ex) begin errors++; $display("FAIL b2b_cpu_data i=%0d addr=%h got %h want %h", i, a, rd, ex); end
                    end else begin
                        ref_write(a, d);
                    end
                end
            end
            begin
                logic [15:0] a, d, rd, ex;
                logic        we;
                int          e;
                for (int i = 0; i < 10; i++) begin
                    we = 1'($urandom_range(0, 1)); a = pick_addr(); d = 16'($urandom);
                    dbg_do(we, a, d, rd, e);
                    order_q.push_back(8'd68);
                    checks++; if (e < exp_edges(a) || e > 2 * L + 3) begin errors++; $display("FAIL b2b_dbg_wait i=%0d got edges=%0d want %0d..%0d", i, e, exp_edges(a), 2 * L + 3); end
                    if (!we) begin
                        ex = ref_read(a);
                        checks++; if (rd !== ex) begin errors++; $display("FAIL b2b_dbg_data i=%0d addr=%h got %h want %h", i, a, rd, ex); end
                    end else begin
                        ref_write(a, d);
                    end
                end
            end
        join
        checks++; if (ack_cnt - a0 != 10 || order_q.size() != 20) begin errors++; $display("FAIL b2b_counts got acks=%0d done=%0d want 10 20", ack_cnt - a0, order_q.size()); end
        for (int i = 1; i < order_q.size(); i++) begin
            checks++; if (order_q[i] == order_q[i-1]) begin errors++; $display("FAIL b2b_alternate at=%0d got %c after %c want alternation", i, order_q[i], order_q[i-1]); end
        end
        checks++; if (ledr !== ref_led) begin errors++; $display("FAIL b2b_led got %h want %h", ledr, ref_led); end
        checks++; if (far_strobes != 0) begin errors++; $display("FAIL bus_addr_range got %0d strobes above 0x3FF want 0", far_strobes); end
    endtask

    initial begin
        reset_L = 1'b0; cpu_re_L = 1'b1; cpu_we_L = 1'b1; cpu_addr = 16'h0; cpu_wdata = 16'h0;
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = 16'h0; dbg_wdata = 16'h0; sw = 16'h0;
        test_reset();
        test_reset_mid_access();
        test_cpu_mem_read();
        test_cpu_io();
        test_tie_alternation();
        test_dbg_write_read();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1);
    end

endmodule
